// File: rtl/cp0_ctrl.sv
// CP0 control: BadVAddr/Count/Compare/Status/Cause/EPC, exception priority and a 2-state commit FSM.
// Optional timer (Count/Compare/TI) is built only when CP0_TIMER_EN is defined.
module cp0_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        WB_valid,
  input  logic        mtc0,
  input  logic        eret,
  input  logic        syscall,
  input  logic        Break,
  input  logic        trap,
  input  logic        ri,
  input  logic        ov_exc,
  input  logic        is_ds,
  input  logic        inst_store,
  input  logic [1:0]  addr_exc,
  input  logic [7:0]  cp0r_addr,
  input  logic [31:0] wdata,
  input  logic [31:0] badvaddr,
  input  logic [31:0] pc,
  input  logic [5:0]  hw_int,
  output logic [67:0] CP0_WB_bus
);
  typedef enum logic {IDLE, COMMIT} state_t;
  state_t state;

  logic [7:0]  im;
  logic        exl, ie, bd;
  logic [7:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc, bad_vaddr;
  logic        exc_happened, int_happened, exc_valid;
  logic [31:0] status_r, cause_r, count_r, compare_r, rdata;
  logic        int_pending, exc_any, sel_adr, go, wr_sel, ti_bit;
  logic [4:0]  sel_code;

  assign status_r = {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
  assign cause_r  = {bd, 15'd0, ip, 1'b0, exc_code, 2'b00};
  assign int_pending = ie & ~exl & (|(ip & im));

  always_comb begin
    exc_any  = 1'b1;
    sel_adr  = 1'b0;
    sel_code = 5'd0;
    if (int_pending)      sel_code = 5'd0;
    else if (addr_exc[1]) begin sel_code = 5'd4; sel_adr = 1'b1; end
    else if (ri)          sel_code = 5'd10;
    else if (ov_exc)      sel_code = 5'd12;
    else if (syscall)     sel_code = 5'd8;
    else if (Break)       sel_code = 5'd9;
    else if (trap)        sel_code = 5'd13;
    else if (addr_exc[0]) begin sel_code = inst_store ? 5'd5 : 5'd4; sel_adr = 1'b1; end
    else                  exc_any = 1'b0;
  end

  assign go     = (state == IDLE) & WB_valid & (mtc0 | eret | exc_any);
  // A coinciding exception suppresses the mtc0 write.
  assign wr_sel = go & ~exc_any & mtc0 & (cp0r_addr[2:0] == 3'd0);

`ifdef CP0_TIMER_EN
  logic [31:0] count, compare;
  logic        tog, ti;
  logic        wr_count, wr_compare;

  assign wr_count   = wr_sel & (cp0r_addr[7:3] == 5'd9);
  assign wr_compare = wr_sel & (cp0r_addr[7:3] == 5'd11);

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= 32'd0;
      compare <= 32'd0;
      tog     <= 1'b0;
      ti      <= 1'b0;
    end else begin
      tog <= ~tog;
      if (wr_count)  count <= wdata;
      else if (tog)  count <= count + 32'd1;
      if (wr_compare) compare <= wdata;
      if (wr_compare)              ti <= 1'b0;
      else if (count == compare)   ti <= 1'b1;
    end
  end

  assign count_r   = count;
  assign compare_r = compare;
  assign ti_bit    = ti;
`else
  assign count_r   = 32'd0;
  assign compare_r = 32'd0;
  assign ti_bit    = 1'b0;
`endif

  always_comb begin
    rdata = 32'd0;
    if (cp0r_addr[2:0] == 3'd0) begin
      case (cp0r_addr[7:3])
        5'd8:    rdata = bad_vaddr;
        5'd9:    rdata = count_r;
        5'd11:   rdata = compare_r;
        5'd12:   rdata = status_r;
        5'd13:   rdata = cause_r;
        5'd14:   rdata = epc;
        default: rdata = 32'd0;
      endcase
    end
    if (reset) rdata = (cp0r_addr == 8'h60) ? 32'h0040_0000 : 32'd0;
  end

  assign CP0_WB_bus = {exc_happened & ~reset, int_happened & ~reset, exc_valid & ~reset,
                       rdata, reset ? 32'd0 : epc, reset | ~go};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      im           <= 8'd0;
      exl          <= 1'b0;
      ie           <= 1'b0;
      bd           <= 1'b0;
      ip           <= 8'd0;
      exc_code     <= 5'd0;
      epc          <= 32'd0;
      bad_vaddr    <= 32'd0;
      exc_happened <= 1'b0;
      int_happened <= 1'b0;
      exc_valid    <= 1'b0;
    end else begin
      ip[7:2] <= {hw_int[5] | ti_bit, hw_int[4:0]};
      case (state)
        IDLE: if (go) begin
          state        <= COMMIT;
          exc_happened <= exc_any & ~int_pending;
          int_happened <= int_pending;
          exc_valid    <= exc_any | eret;
          if (exc_any) begin
            epc      <= is_ds ? pc - 32'd4 : pc;
            bd       <= is_ds;
            exc_code <= sel_code;
            exl      <= 1'b1;
            if (sel_adr) bad_vaddr <= badvaddr;
          end else begin
            if (eret) exl <= 1'b0;
            if (wr_sel) begin
              case (cp0r_addr[7:3])
                5'd12: begin im <= wdata[15:8]; exl <= wdata[1]; ie <= wdata[0]; end
                5'd13: ip[1:0] <= wdata[9:8];
                5'd14: epc <= wdata;
                default: ;
              endcase
            end
          end
        end
        COMMIT: begin
          state        <= IDLE;
          exc_happened <= 1'b0;
          int_happened <= 1'b0;
          exc_valid    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cp0_ctrl.sv
// Random + directed bench for cp0_ctrl against a word-level CP0 reference model.
module tb_cp0_ctrl;
  logic        clk = 1'b0;
  logic        reset, WB_valid, mtc0, eret, syscall, Break, trap, ri, ov_exc, is_ds, inst_store;
  logic [1:0]  addr_exc;
  logic [7:0]  cp0r_addr;
  logic [31:0] wdata, badvaddr, pc;
  logic [5:0]  hw_int;
  logic [67:0] CP0_WB_bus;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  cp0_ctrl dut (
    .clk(clk), .reset(reset), .WB_valid(WB_valid), .mtc0(mtc0), .eret(eret),
    .syscall(syscall), .Break(Break), .trap(trap), .ri(ri), .ov_exc(ov_exc),
    .is_ds(is_ds), .inst_store(inst_store), .addr_exc(addr_exc), .cp0r_addr(cp0r_addr),
    .wdata(wdata), .badvaddr(badvaddr), .pc(pc), .hw_int(hw_int), .CP0_WB_bus(CP0_WB_bus)
  );

  // Reference model: architectural registers as 32-bit words.
  logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare;
  bit m_ti, m_tog, m_busy, m_exh, m_inth, m_excv;

  task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    if (reset) return (a == 8'h60) ? 32'h0040_0000 : 32'h0;
    case (a)
      8'h40: return m_badv;
      8'h48: return m_count;
      8'h58: return m_compare;
      8'h60: return m_status;
      8'h68: return m_cause;
      8'h70: return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_intp();
    return m_status[0] && !m_status[1] && (|(m_cause[15:8] & m_status[15:8]));
  endfunction

  function automatic int m_code(output bit adr);
    adr = 0;
    if (m_intp()) return 0;
    if (addr_exc[1]) begin adr = 1; return 4; end
    if (ri) return 10;
    if (ov_exc) return 12;
    if (syscall) return 8;
    if (Break) return 9;
    if (trap) return 13;
    if (addr_exc[0]) begin adr = 1; return inst_store ? 5 : 4; end
    return -1;
  endfunction

  task automatic step();
    bit adr, go, intp;
    int code;
    logic [67:0] exp;
`ifdef CP0_TIMER_EN
    bit wc, wcmp;
`endif
    intp = m_intp();
    code = m_code(adr);
    go = !m_busy && WB_valid && (mtc0 || eret || code >= 0);
    #1;
    exp = {(m_busy && !reset) ? {m_exh, m_inth, m_excv} : 3'b000, m_read(cp0r_addr),
           reset ? 32'h0 : m_epc, reset || !go};
    chk("bus", CP0_WB_bus, exp);
    @(posedge clk);
    if (reset) begin
      m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_badv = 0; m_count = 0; m_compare = 0;
      m_ti = 0; m_tog = 0; m_busy = 0; m_exh = 0; m_inth = 0; m_excv = 0;
    end else begin
`ifdef CP0_TIMER_EN
      wc   = go && code < 0 && mtc0 && cp0r_addr == 8'h48;
      wcmp = go && code < 0 && mtc0 && cp0r_addr == 8'h58;
      m_cause[15:10] = {hw_int[5] | m_ti, hw_int[4:0]};
      if (wcmp) m_ti = 0; else if (m_count == m_compare) m_ti = 1;
      if (wc) m_count = wdata; else if (m_tog) m_count = m_count + 1;
      if (wcmp) m_compare = wdata;
      m_tog = !m_tog;
`else
      m_cause[15:10] = hw_int;
`endif
      if (go) begin
        m_exh  = code >= 0 && !intp;
        m_inth = intp;
        m_excv = code >= 0 || eret;
        if (code >= 0) begin
          m_epc = is_ds ? pc - 32'd4 : pc;
          m_cause[31] = is_ds;
          m_cause[6:2] = code[4:0];
          m_status[1] = 1'b1;
          if (adr) m_badv = badvaddr;
        end else begin
          if (eret) m_status[1] = 1'b0;
          if (mtc0) begin
            if (cp0r_addr == 8'h60) m_status = (m_status & ~32'hFF03) | (wdata & 32'hFF03);
            if (cp0r_addr == 8'h68) m_cause[9:8] = wdata[9:8];
            if (cp0r_addr == 8'h70) m_epc = wdata;
          end
        end
      end
      m_busy = go;
    end
    @(negedge clk);
  endtask

  task automatic clr();
    reset = 0; WB_valid = 0; mtc0 = 0; eret = 0; syscall = 0; Break = 0; trap = 0; ri = 0;
    ov_exc = 0; is_ds = 0; inst_store = 0; addr_exc = 0; cp0r_addr = 0; wdata = 0;
    badvaddr = 0; pc = 0; hw_int = 0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    WB_valid = 0; cp0r_addr = a;
    #1 chk(tag, CP0_WB_bus[64:33], exp);
    step();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    clr(); WB_valid = 1; mtc0 = 1; cp0r_addr = a; wdata = d;
    step();
    clr(); step();
  endtask

  initial begin
    bit found;
    clr();
    @(negedge clk);
    reset = 1; cp0r_addr = 8'h60;
    #1 chk("rst_bus", CP0_WB_bus, {3'b000, 32'h0040_0000, 32'h0, 1'b1});
    step(); step();
    clr();
    rd("rst_cause", 8'h68, 32'h0);
    rd("rst_status", 8'h60, 32'h0040_0000);

    // syscall
    syscall = 1; WB_valid = 1; pc = 32'hBFC0_0100;
    #1 chk("sys_over0", CP0_WB_bus[0], 1'b0);
    step();
    clr(); cp0r_addr = 8'h70;
    #1 chk("sys_commit", {CP0_WB_bus[67:65], CP0_WB_bus[0]}, 4'b1011);
    chk("sys_epc", CP0_WB_bus[32:1], 32'hBFC0_0100);
    step();
    rd("sys_cause", 8'h68, 32'h0000_0020);
    rd("sys_status", 8'h60, 32'h0040_0002);

    // data address errors in a delay slot, load then store
    for (int s = 0; s < 2; s++) begin
      clr(); WB_valid = 1; addr_exc = 2'b01; is_ds = 1; inst_store = s[0];
      pc = 32'h8000_0010; badvaddr = 32'h0000_0003;
      step(); clr(); step();
      rd("ade_epc", 8'h70, 32'h8000_000C);
      rd("ade_cause", 8'h68, s ? 32'h8000_0014 : 32'h8000_0010);
      rd("ade_badv", 8'h40, 32'h0000_0003);
    end

    // interrupt then eret
    wr(8'h60, 32'h0000_8001);
    rd("int_status", 8'h60, 32'h0040_8001);
    hw_int = 6'h20; step(); step();
    WB_valid = 1;
    #1 chk("int_over0", CP0_WB_bus[0], 1'b0);
    step();
    clr(); hw_int = 6'h20;
    #1 chk("int_commit", CP0_WB_bus[67:65], 3'b011);
    step();
    rd("int_cause", 8'h68, 32'h0000_8000);
    WB_valid = 1; eret = 1; step();
    clr(); hw_int = 6'h20;
    #1 chk("eret_commit", CP0_WB_bus[67:65], 3'b001);
    step();
    rd("eret_status", 8'h60, 32'h0040_8001);

    // ri + ov together
    clr(); step(); step();
    WB_valid = 1; ri = 1; ov_exc = 1; step(); clr(); step();
    rd("ri_cause", 8'h68, 32'h0000_0028);

`ifdef CP0_TIMER_EN
    wr(8'h58, 32'd5);
    wr(8'h48, 32'd0);
    found = 0; cp0r_addr = 8'h68;
    for (int i = 0; i < 24 && !found; i++) begin
      #1 if (CP0_WB_bus[48]) found = 1;
      if (!found) step();
    end
    chk("ti_seen", found, 1'b1);
    wr(8'h58, 32'h0000_1000);
    step(); step();
    cp0r_addr = 8'h68;
    #1 chk("ti_clr", CP0_WB_bus[48], 1'b0);
    step();
`else
    found = 0;
    wr(8'h48, 32'h0000_1234);
    rd("count_zero", 8'h48, 32'h0);
`endif

    for (int n = 0; n < 3000; n++) begin
      logic [4:0] r;
      reset = ($urandom_range(0, 63) == 0);
      WB_valid = $urandom_range(0, 1);
      mtc0 = ($urandom_range(0, 3) == 0);
      eret = ($urandom_range(0, 7) == 0);
      syscall = ($urandom_range(0, 15) == 0);
      Break = ($urandom_range(0, 15) == 0);
      trap = ($urandom_range(0, 15) == 0);
      ri = ($urandom_range(0, 15) == 0);
      ov_exc = ($urandom_range(0, 15) == 0);
      addr_exc = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      is_ds = $urandom_range(0, 1);
      inst_store = $urandom_range(0, 1);
      case ($urandom_range(0, 6))
        0: r = 5'd8; 1: r = 5'd9; 2: r = 5'd11; 3: r = 5'd12; 4: r = 5'd13; 5: r = 5'd14;
        default: r = 5'($urandom_range(0, 31));
      endcase
      cp0r_addr = {r, ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd0};
      wdata = $urandom; pc = $urandom; badvaddr = $urandom;
      if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom_range(0, 63));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
